// File: rtl/cache_control_nway.sv
// cache_control_nway: control FSM for a WAYS-way set-associative cache.
// It sequences hits, dirty write-back, line fill and write-through writes,
// and picks victims by tree pseudo-LRU with invalid ways taking priority.
// Ports:
//   clk, rst                      single clock, synchronous active-high reset
//   mem_read/mem_write/mem_resp   CPU request/completion handshake
//   mem_byte_enable               CPU write mask; a zero mask writes nothing
//   hit_vec/valid_vec/dirty_vec   per-way status of the addressed set
//   plru_in/plru_out/plru_write   PLRU tree read, updated value and write strobe
//   way_sel, data_write, tag_write, dirty_set, dirty_clear,
//   data_in_sel, pmem_addr_sel, pmem_src_sel   datapath controls
//   pmem_read/pmem_write/pmem_resp             physical memory handshake
// All controls are combinational from state and inputs.
module cache_control_nway #(
  parameter int WAYS          = 4,
  parameter bit WRITE_THROUGH = 1'b0,
  localparam int WB           = $clog2(WAYS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [1:0]      mem_byte_enable,
  output logic            mem_resp,
  input  logic [WAYS-1:0] hit_vec,
  input  logic [WAYS-1:0] valid_vec,
  input  logic [WAYS-1:0] dirty_vec,
  input  logic [WAYS-2:0] plru_in,
  output logic [WAYS-2:0] plru_out,
  output logic            plru_write,
  output logic [WB-1:0]   way_sel,
  output logic            data_write,
  output logic            tag_write,
  output logic            dirty_set,
  output logic            dirty_clear,
  output logic            data_in_sel,
  output logic            pmem_addr_sel,
  output logic            pmem_src_sel,
  output logic            pmem_read,
  output logic            pmem_write,
  input  logic            pmem_resp
);

  typedef enum logic [2:0] {
    IDLE, WRITE_BACK, FILL, FILL_DONE, WT_WRITE
  } state_t;

  state_t        state;
  logic [WB-1:0] victim_q;

  logic          req;
  logic          is_write;
  logic          hit;
  logic          wr_data;
  logic [WB-1:0] hit_way;
  logic [WB-1:0] inv_way;
  logic          inv_found;
  logic [WB-1:0] plru_way;
  logic [WB-1:0] victim;
  logic          victim_dirty;

  // A simultaneous read and write is handled as a write.
  assign req      = mem_read | mem_write;
  assign is_write = mem_write;
  assign hit      = |hit_vec;
  assign wr_data  = mem_write & (|mem_byte_enable);

  // Lowest-index hit way (loop runs downward so the lowest index wins).
  always_comb begin
    hit_way = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (hit_vec[i]) hit_way = WB'(i);
    end
  end

  // Lowest-index invalid way.
  always_comb begin
    inv_way   = '0;
    inv_found = 1'b0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!valid_vec[i]) begin
        inv_way   = WB'(i);
        inv_found = 1'b1;
      end
    end
  end

  // Tree walk: node i has children 2i+1 (lower half) and 2i+2 (upper half).
  // Each visited node bit becomes the next way-index bit, MSB first.
  always_comb begin
    int unsigned node;
    node     = 0;
    plru_way = '0;
    for (int l = 0; l < WB; l++) begin
      plru_way = (plru_way << 1) | WB'(plru_in[node]);
      node     = 2 * node + 1 + int'(plru_in[node]);
    end
  end

  // Point every node on the accessed way's path away from that way.
  always_comb begin
    int unsigned node;
    logic        b;
    node     = 0;
    plru_out = plru_in;
    for (int l = 0; l < WB; l++) begin
      b              = hit_way[WB-1-l];
      plru_out[node] = ~b;
      node           = 2 * node + 1 + int'(b);
    end
  end

  assign victim       = inv_found ? inv_way : plru_way;
  assign victim_dirty = valid_vec[victim] & dirty_vec[victim];

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      victim_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req && !hit) begin
            if (is_write && WRITE_THROUGH) begin
              // No allocation on a write-through write miss.
              state <= WT_WRITE;
            end else begin
              victim_q <= victim;
              state    <= victim_dirty ? WRITE_BACK : FILL;
            end
          end else if (req && hit && wr_data && WRITE_THROUGH) begin
            state <= WT_WRITE;
          end
        end
        WRITE_BACK: if (pmem_resp) state <= FILL;
        FILL:       if (pmem_resp) state <= FILL_DONE;
        FILL_DONE:  state <= IDLE;
        WT_WRITE:   if (pmem_resp) state <= IDLE;
        default:    state <= IDLE;
      endcase
    end
  end

  always_comb begin
    mem_resp      = 1'b0;
    plru_write    = 1'b0;
    way_sel       = '0;
    data_write    = 1'b0;
    tag_write     = 1'b0;
    dirty_set     = 1'b0;
    dirty_clear   = 1'b0;
    data_in_sel   = 1'b0;
    pmem_addr_sel = 1'b0;
    pmem_src_sel  = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (req && hit) begin
            way_sel    = hit_way;
            plru_write = 1'b1;
            if (wr_data) begin
              data_write = 1'b1;
              // Write-through completes only after the memory write.
              if (!WRITE_THROUGH) begin
                dirty_set = 1'b1;
                mem_resp  = 1'b1;
              end
            end else begin
              // Reads, and writes with an empty mask, finish immediately.
              mem_resp = 1'b1;
            end
          end
        end
        WRITE_BACK: begin
          pmem_write    = 1'b1;
          pmem_addr_sel = 1'b1;
          way_sel       = victim_q;
        end
        FILL: begin
          pmem_read = 1'b1;
          way_sel   = victim_q;
        end
        FILL_DONE: begin
          data_in_sel = 1'b1;
          data_write  = 1'b1;
          tag_write   = 1'b1;
          dirty_clear = 1'b1;
          way_sel     = victim_q;
        end
        WT_WRITE: begin
          pmem_write   = 1'b1;
          pmem_src_sel = 1'b1;
          mem_resp     = pmem_resp;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_control_nway.sv
// Testbench for cache_control_nway (WAYS=4): one write-back and one
// write-through instance share stimulus; a scoreboard queue holds the
// expected output vector per cycle and a negedge monitor checks it.
module tb_cache_control_nway;

  typedef struct packed {
    logic       mem_resp;
    logic       plru_write;
    logic [2:0] plru_out;
    logic [1:0] way_sel;
    logic       data_write;
    logic       tag_write;
    logic       dirty_set;
    logic       dirty_clear;
    logic       data_in_sel;
    logic       pmem_addr_sel;
    logic       pmem_src_sel;
    logic       pmem_read;
    logic       pmem_write;
  } ov_t;

  typedef struct {
    string name;
    int    sel;
    ov_t   exp;
  } sb_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       mem_read, mem_write, pmem_resp;
  logic [1:0] mem_byte_enable;
  logic [3:0] hit_vec, valid_vec, dirty_vec;
  logic [2:0] plru_in;

  logic       a_mem_resp, a_plru_write, a_data_write, a_tag_write, a_dirty_set;
  logic       a_dirty_clear, a_data_in_sel, a_pmem_addr_sel, a_pmem_src_sel;
  logic       a_pmem_read, a_pmem_write;
  logic [2:0] a_plru_out;
  logic [1:0] a_way_sel;
  logic       b_mem_resp, b_plru_write, b_data_write, b_tag_write, b_dirty_set;
  logic       b_dirty_clear, b_data_in_sel, b_pmem_addr_sel, b_pmem_src_sel;
  logic       b_pmem_read, b_pmem_write;
  logic [2:0] b_plru_out;
  logic [1:0] b_way_sel;

  int  checks = 0;
  int  errors = 0;
  sb_t sb[$];

  always #5 clk = ~clk;

  cache_control_nway #(.WAYS(4), .WRITE_THROUGH(1'b0)) dut_wb (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_enable(mem_byte_enable), .mem_resp(a_mem_resp),
    .hit_vec(hit_vec), .valid_vec(valid_vec), .dirty_vec(dirty_vec),
    .plru_in(plru_in), .plru_out(a_plru_out), .plru_write(a_plru_write),
    .way_sel(a_way_sel), .data_write(a_data_write), .tag_write(a_tag_write),
    .dirty_set(a_dirty_set), .dirty_clear(a_dirty_clear),
    .data_in_sel(a_data_in_sel), .pmem_addr_sel(a_pmem_addr_sel),
    .pmem_src_sel(a_pmem_src_sel), .pmem_read(a_pmem_read),
    .pmem_write(a_pmem_write), .pmem_resp(pmem_resp)
  );

  cache_control_nway #(.WAYS(4), .WRITE_THROUGH(1'b1)) dut_wt (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_enable(mem_byte_enable), .mem_resp(b_mem_resp),
    .hit_vec(hit_vec), .valid_vec(valid_vec), .dirty_vec(dirty_vec),
    .plru_in(plru_in), .plru_out(b_plru_out), .plru_write(b_plru_write),
    .way_sel(b_way_sel), .data_write(b_data_write), .tag_write(b_tag_write),
    .dirty_set(b_dirty_set), .dirty_clear(b_dirty_clear),
    .data_in_sel(b_data_in_sel), .pmem_addr_sel(b_pmem_addr_sel),
    .pmem_src_sel(b_pmem_src_sel), .pmem_read(b_pmem_read),
    .pmem_write(b_pmem_write), .pmem_resp(pmem_resp)
  );

  ov_t ov_wb, ov_wt;
  assign ov_wb = {a_mem_resp, a_plru_write, a_plru_out, a_way_sel, a_data_write,
                  a_tag_write, a_dirty_set, a_dirty_clear, a_data_in_sel,
                  a_pmem_addr_sel, a_pmem_src_sel, a_pmem_read, a_pmem_write};
  assign ov_wt = {b_mem_resp, b_plru_write, b_plru_out, b_way_sel, b_data_write,
                  b_tag_write, b_dirty_set, b_dirty_clear, b_data_in_sel,
                  b_pmem_addr_sel, b_pmem_src_sel, b_pmem_read, b_pmem_write};

  // Expected-vector builder, fields in ov_t order.
  function automatic ov_t x(bit r, bit pw, bit [2:0] po, bit [1:0] ws, bit dw,
                            bit tw, bit ds, bit dc, bit dis, bit pas, bit pss,
                            bit prd, bit pwr);
    x = {r, pw, po, ws, dw, tw, ds, dc, dis, pas, pss, prd, pwr};
  endfunction

  function automatic ov_t z(bit [2:0] po);
    z = x(0, 0, po, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  // Drive one cycle of inputs and queue the expected outputs for it.
  task automatic cyc(input string nm, input int sel, input bit r, input bit mr,
                     input bit mw, input bit [1:0] be, input bit [3:0] hv,
                     input bit [3:0] vv, input bit [3:0] dv, input bit [2:0] pl,
                     input bit pr, input ov_t e);
    rst             = r;
    mem_read        = mr;
    mem_write       = mw;
    mem_byte_enable = be;
    hit_vec         = hv;
    valid_vec       = vv;
    dirty_vec       = dv;
    plru_in         = pl;
    pmem_resp       = pr;
    sb.push_back('{name: nm, sel: sel, exp: e});
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops one expectation per cycle and compares the chosen instance.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      sb_t  e;
      ov_t  act;
      e   = sb.pop_front();
      act = (e.sel == 0) ? ov_wb : ov_wt;
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s: got %b required %b", e.name, act, e.exp);
      end
      checks++;
      if ((a_pmem_read && a_pmem_write) || (b_pmem_read && b_pmem_write)) begin
        errors++;
        $display("FAIL %s_overlap: pmem_read and pmem_write both high", e.name);
      end
    end
  end

  always @(negedge clk) begin
    assert ($onehot0(hit_vec)) else $error("hit_vec has more than one bit set");
  end

  initial begin
    rst = 1'b1; mem_read = 0; mem_write = 0; mem_byte_enable = 0;
    hit_vec = 0; valid_vec = 0; dirty_vec = 0; plru_in = 0; pmem_resp = 0;
    @(posedge clk);
    #1;
    // ---------------- write-back instance ----------------
    cyc("rst_gate",     0, 1, 1, 0, 2'b00, 4'b0100, 4'b1111, 4'b0000, 3'b000, 0, z(3'b100));
    cyc("rd_hit",       0, 0, 1, 0, 2'b00, 4'b0100, 4'b1111, 4'b0000, 3'b000, 0, x(1,1,3'b100,2, 0,0,0,0,0,0,0,0,0));
    cyc("idle1",        0, 0, 0, 0, 2'b00, 4'b0000, 4'b1111, 4'b0000, 3'b000, 0, z(3'b011));
    cyc("rmiss_idle",   0, 0, 1, 0, 2'b00, 4'b0000, 4'b1111, 4'b0000, 3'b000, 0, z(3'b011));
    cyc("fill_w1",      0, 0, 1, 0, 2'b00, 4'b0000, 4'b1111, 4'b0000, 3'b000, 0, x(0,0,3'b011,0, 0,0,0,0,0,0,0,1,0));
    cyc("fill_w2",      0, 0, 1, 0, 2'b00, 4'b0000, 4'b1111, 4'b0000, 3'b000, 0, x(0,0,3'b011,0, 0,0,0,0,0,0,0,1,0));
    cyc("fill_resp",    0, 0, 1, 0, 2'b00, 4'b0000, 4'b1111, 4'b0000, 3'b000, 1, x(0,0,3'b011,0, 0,0,0,0,0,0,0,1,0));
    cyc("fill_done",    0, 0, 1, 0, 2'b00, 4'b0000, 4'b1111, 4'b0000, 3'b000, 0, x(0,0,3'b011,0, 1,1,0,1,1,0,0,0,0));
    cyc("retry_hit",    0, 0, 1, 0, 2'b00, 4'b0001, 4'b1111, 4'b0000, 3'b000, 0, x(1,1,3'b011,0, 0,0,0,0,0,0,0,0,0));
    cyc("idle2",        0, 0, 0, 0, 2'b00, 4'b0000, 4'b1111, 4'b0000, 3'b000, 0, z(3'b011));
    cyc("dmiss_idle",   0, 0, 1, 0, 2'b00, 4'b0000, 4'b1111, 4'b1000, 3'b101, 0, z(3'b111));
    cyc("wb_w",         0, 0, 1, 0, 2'b00, 4'b0000, 4'b1111, 4'b1000, 3'b101, 0, x(0,0,3'b111,3, 0,0,0,0,0,1,0,0,1));
    cyc("wb_resp",      0, 0, 1, 0, 2'b00, 4'b0000, 4'b1111, 4'b1000, 3'b101, 1, x(0,0,3'b111,3, 0,0,0,0,0,1,0,0,1));
    cyc("wb_fill",      0, 0, 1, 0, 2'b00, 4'b0000, 4'b1111, 4'b1000, 3'b101, 0, x(0,0,3'b111,3, 0,0,0,0,0,0,0,1,0));
    cyc("wb_fill_resp", 0, 0, 1, 0, 2'b00, 4'b0000, 4'b1111, 4'b1000, 3'b101, 1, x(0,0,3'b111,3, 0,0,0,0,0,0,0,1,0));
    cyc("wb_fill_done", 0, 0, 1, 0, 2'b00, 4'b0000, 4'b1111, 4'b1000, 3'b101, 0, x(0,0,3'b111,3, 1,1,0,1,1,0,0,0,0));
    cyc("wb_retry_hit", 0, 0, 1, 0, 2'b00, 4'b1000, 4'b1111, 4'b1000, 3'b101, 0, x(1,1,3'b000,3, 0,0,0,0,0,0,0,0,0));
    cyc("idle3",        0, 0, 0, 0, 2'b00, 4'b0000, 4'b1111, 4'b0000, 3'b000, 0, z(3'b011));
    cyc("inv_idle",     0, 0, 1, 0, 2'b00, 4'b0000, 4'b1011, 4'b1000, 3'b101, 0, z(3'b111));
    cyc("inv_fill",     0, 0, 1, 0, 2'b00, 4'b0000, 4'b1011, 4'b1000, 3'b101, 1, x(0,0,3'b111,2, 0,0,0,0,0,0,0,1,0));
    cyc("inv_done",     0, 0, 1, 0, 2'b00, 4'b0000, 4'b1011, 4'b1000, 3'b101, 0, x(0,0,3'b111,2, 1,1,0,1,1,0,0,0,0));
    cyc("idle4",        0, 0, 0, 0, 2'b00, 4'b0000, 4'b1111, 4'b0000, 3'b000, 0, z(3'b011));
    cyc("wr_hit",       0, 0, 0, 1, 2'b11, 4'b0010, 4'b1111, 4'b0000, 3'b000, 0, x(1,1,3'b001,1, 1,0,1,0,0,0,0,0,0));
    cyc("idle5",        0, 0, 0, 0, 2'b00, 4'b0000, 4'b1111, 4'b0000, 3'b000, 0, z(3'b011));
    cyc("wmiss_idle",   0, 0, 0, 1, 2'b11, 4'b0000, 4'b1111, 4'b1000, 3'b101, 0, z(3'b111));
    cyc("wmiss_wb",     0, 0, 0, 1, 2'b11, 4'b0000, 4'b1111, 4'b1000, 3'b101, 0, x(0,0,3'b111,3, 0,0,0,0,0,1,0,0,1));
    cyc("wmiss_wbresp", 0, 0, 0, 1, 2'b11, 4'b0000, 4'b1111, 4'b1000, 3'b101, 1, x(0,0,3'b111,3, 0,0,0,0,0,1,0,0,1));
    cyc("wmiss_fill",   0, 0, 0, 1, 2'b11, 4'b0000, 4'b1111, 4'b1000, 3'b101, 0, x(0,0,3'b111,3, 0,0,0,0,0,0,0,1,0));
    cyc("rst_in_fill",  0, 1, 0, 1, 2'b11, 4'b0000, 4'b1111, 4'b1000, 3'b101, 0, z(3'b111));
    cyc("post_rst",     0, 0, 0, 0, 2'b00, 4'b0000, 4'b1111, 4'b0000, 3'b000, 0, z(3'b011));
    checks++;
    if (dut_wb.victim_q !== 2'd0) begin
      errors++;
      $display("FAIL victim_q_rst: got %0d required 0", dut_wb.victim_q);
    end
    cyc("rd_and_wr",    0, 0, 1, 1, 2'b11, 4'b0001, 4'b1111, 4'b0000, 3'b000, 0, x(1,1,3'b011,0, 1,0,1,0,0,0,0,0,0));
    cyc("idle6",        0, 0, 0, 0, 2'b00, 4'b0000, 4'b1111, 4'b0000, 3'b000, 0, z(3'b011));
    // ---------------- write-through instance ----------------
    cyc("wt_rst",       1, 1, 0, 0, 2'b00, 4'b0000, 4'b1111, 4'b0000, 3'b000, 0, z(3'b011));
    cyc("wt_wr_hit",    1, 0, 0, 1, 2'b01, 4'b0010, 4'b1111, 4'b0000, 3'b000, 0, x(0,1,3'b001,1, 1,0,0,0,0,0,0,0,0));
    cyc("wt_write",     1, 0, 0, 1, 2'b01, 4'b0010, 4'b1111, 4'b0000, 3'b000, 0, x(0,0,3'b001,0, 0,0,0,0,0,0,1,0,1));
    cyc("wt_resp",      1, 0, 0, 1, 2'b01, 4'b0010, 4'b1111, 4'b0000, 3'b000, 1, x(1,0,3'b001,0, 0,0,0,0,0,0,1,0,1));
    cyc("wt_idle1",     1, 0, 0, 0, 2'b00, 4'b0000, 4'b1111, 4'b0000, 3'b000, 0, z(3'b011));
    cyc("wt_wmiss",     1, 0, 0, 1, 2'b11, 4'b0000, 4'b1111, 4'b1111, 3'b000, 0, z(3'b011));
    cyc("wt_wm_write",  1, 0, 0, 1, 2'b11, 4'b0000, 4'b1111, 4'b1111, 3'b000, 0, x(0,0,3'b011,0, 0,0,0,0,0,0,1,0,1));
    cyc("wt_wm_resp",   1, 0, 0, 1, 2'b11, 4'b0000, 4'b1111, 4'b1111, 3'b000, 1, x(1,0,3'b011,0, 0,0,0,0,0,0,1,0,1));
    cyc("wt_idle2",     1, 0, 0, 0, 2'b00, 4'b0000, 4'b1111, 4'b0000, 3'b000, 0, z(3'b011));
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations never checked, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
